tod_counter: RTL and testbench
==============================

# tod_counter

Parametrised time-of-day counter: seconds, minutes and hours with a selectable 12 h/24 h display, run/pause, a built-in prescaler and a validated time-set handshake. It replaces the fixed 12-hour chained-digit counter in the clock datapath. Its six BCD digit outputs and PM flag feed the seven-segment scan driver directly.

## Interface
- DIV_CNT, default 1: clk cycles per second step (≥1); 1 = advance every enabled cycle (simulation).
- INIT_HOUR, default 0: reset hour, binary 0–23.
- INIT_MIN, default 0: reset minute, binary 0–59.
- INIT_SEC, default 0: reset second, binary 0–59.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- run  in  1  1 = count; 0 = hold time and prescaler.
- mode_24h  in  1  display mode; 1 = 00–23, 0 = 12 h with pm.
- set_req  in  1  load request, sampled each cycle.
- set_hour  in  5  binary hour for load.
- set_min  in  6  binary minute for load.
- set_sec  in  6  binary second for load.
- set_ack  out  1  one-cycle pulse: load accepted.
- set_err  out  1  one-cycle pulse: load rejected (out of range).
- sec0, sec1, min0, min1, hour0, hour1  out  4 each  BCD display digits (units, tens).
- pm  out  1  1 when internal hour ≥ 12 (valid in both modes).
- day_wrap  out  1  one-cycle pulse on 23:59:59 → 00:00:00.
- alarm_we, alarm_hour(5), alarm_min(6), alarm_arm  in  alarm controls (see Configuration).
- alarm_hit  out  1  one-cycle alarm pulse.

## Operation
- State: prescaler count p (0..DIV_CNT-1), internal 24 h time as BCD digits s0,s1,m0,m1,h0,h1.
- Step event: run=1 and p==DIV_CNT-1 → p←0 and time +1 s. run=1 otherwise → p+1. run=0 → p and time hold.
- Carry chain: s0 9→0 carries to s1; s1 5→0 carries to m0; m0 9→0 carries to m1; m1 5→0 carries to hour. Hour 09→10, 19→20, 23→00.
- day_wrap asserts in the cycle after the step that produces 00:00:00 from 23:59:59.
- Set: set_req=1 with set_hour≤23, set_min≤59, set_sec≤59 → time loads the binary→BCD value, p←0, and set_ack pulses. Any field out of range → time unchanged, set_err pulses. Set has priority over a coincident step; that step is discarded. Holding set_req high reloads and pulses every cycle.
- Display is a combinational decode of the state registers, with no extra register:
  - 24 h mode: digits = internal time.
  - 12 h mode: hour 0 → 12; 1–12 unchanged; 13–23 → hour−12.
  - pm = (hour ≥ 12) in both modes.
  - mode_24h may change any cycle; it affects only the decode.
- Reset: time = INIT_HOUR:INIT_MIN:INIT_SEC, p=0, set_ack=set_err=day_wrap=alarm_hit=0, alarm registers 00:00 and disarmed. INIT values out of range are a configuration error; flag them with a simulation assertion.

## Timing
- Step, set and alarm updates become visible on the clk edge that samples them. Digits change one cycle after the qualifying edge inputs are sampled.
- set_ack and set_err are registered: high in the cycle after set_req is sampled, for exactly one cycle per sampled request.
- With DIV_CNT=N and run held high, steps occur every N cycles. The first step after reset or after a set comes N cycles later.
- rst_n low mid-count or mid-set: all state returns immediately (asynchronously) to reset values. Any pending ack or err is lost.

## Configuration
- TOD_ALARM_EN defined:
  - alarm_we=1 loads alarm_hour and alarm_min if in range (else ignored, no err).
  - alarm_arm enables matching.
  - alarm_hit pulses one cycle when a step or set produces hh:mm:00 equal to the alarm time while armed.
- TOD_ALARM_EN undefined: alarm registers and compare logic are absent, alarm_hit is tied 0, and alarm inputs are ignored.

## Test plan
- Reset with INIT 11:59:58, DIV_CNT=1, run=1 → digits 11:59:58, then 11:59:59, then 12:00:00; pm rises in the 12:00:00 cycle.
- set 23:59:58, run=1, mode_24h=0 → display 11:59:58 pm=1, 11:59:59, then 12:00:00 pm=0 with day_wrap pulse, then 12:00:01.
- DIV_CNT=4, run toggled low for 3 cycles mid-count → step spacing stretches by exactly 3 cycles; no lost or extra steps.
- set_req with set_min=60 → set_err one cycle, time unchanged. set_req coincident with a step, loading 05:06:07 → shows 05:06:07 and set_ack; next step is 4 cycles later at DIV_CNT=4.
- With TOD_ALARM_EN: alarm 00:01 armed, set 00:00:59 → alarm_hit one cycle at 00:01:00. Disarmed → no pulse. Without the macro → alarm_hit stays 0.
- Assert rst_n low while set_req is high → outputs return to INIT immediately; no set_ack after release.

Source files
------------

// File: rtl/tod_counter.sv
// Time-of-day counter: BCD hh:mm:ss with prescaler, validated set handshake, and 12h/24h decode.
// Optional alarm compare is built only when TOD_ALARM_EN is defined.
module tod_counter #(
    parameter int DIV_CNT   = 1,
    parameter int INIT_HOUR = 0,
    parameter int INIT_MIN  = 0,
    parameter int INIT_SEC  = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic       mode_24h,
    input  logic       set_req,
    input  logic [4:0] set_hour,
    input  logic [5:0] set_min,
    input  logic [5:0] set_sec,
    output logic       set_ack,
    output logic       set_err,
    output logic [3:0] sec0,
    output logic [3:0] sec1,
    output logic [3:0] min0,
    output logic [3:0] min1,
    output logic [3:0] hour0,
    output logic [3:0] hour1,
    output logic       pm,
    output logic       day_wrap,
    input  logic       alarm_we,
    input  logic [4:0] alarm_hour,
    input  logic [5:0] alarm_min,
    input  logic       alarm_arm,
    output logic       alarm_hit
);

    localparam int              PW     = (DIV_CNT > 1) ? $clog2(DIV_CNT) : 1;
    localparam logic [PW-1:0]   P_LAST = PW'(DIV_CNT - 1);
    localparam logic [3:0]      INIT_H1 = 4'(INIT_HOUR / 10);
    localparam logic [3:0]      INIT_H0 = 4'(INIT_HOUR % 10);
    localparam logic [3:0]      INIT_M1 = 4'(INIT_MIN / 10);
    localparam logic [3:0]      INIT_M0 = 4'(INIT_MIN % 10);
    localparam logic [3:0]      INIT_S1 = 4'(INIT_SEC / 10);
    localparam logic [3:0]      INIT_S0 = 4'(INIT_SEC % 10);
    localparam bit              INIT_OK = (INIT_HOUR >= 0) && (INIT_HOUR <= 23) &&
                                          (INIT_MIN >= 0) && (INIT_MIN <= 59) &&
                                          (INIT_SEC >= 0) && (INIT_SEC <= 59) &&
                                          (DIV_CNT >= 1);

    a_init_range: assert property (@(posedge clk) INIT_OK)
        else $error("tod_counter: INIT time or DIV_CNT out of range");

    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [3:0] t;
        t = 4'(v / 6'd10);
        return {t, 4'(v - 6'(t) * 6'd10)};
    endfunction

    logic [PW-1:0] r_p;
    logic [3:0]    r_s0, r_s1, r_m0, r_m1, r_h0, r_h1;
    logic          r_set_ack, r_set_err, r_day_wrap;

    logic          w_step, w_step_go, w_set_ok, w_set_go, w_last, w_upd;
    logic [7:0]    w_sh, w_sm, w_ss;
    logic [3:0]    w_inc_s0, w_inc_s1, w_inc_m0, w_inc_m1, w_inc_h0, w_inc_h1;
    logic [3:0]    w_nx_s0, w_nx_s1, w_nx_m0, w_nx_m1, w_nx_h0, w_nx_h1;
    logic [4:0]    w_hour_bin, w_h12;

    assign w_step    = run && (r_p == P_LAST);
    // Any request, valid or not, swallows a coincident step.
    assign w_step_go = w_step && !set_req;
    assign w_set_ok  = (set_hour <= 5'd23) && (set_min <= 6'd59) && (set_sec <= 6'd59);
    assign w_set_go  = set_req && w_set_ok;
    assign w_upd     = w_set_go || w_step_go;
    assign w_sh      = bin2bcd({1'b0, set_hour});
    assign w_sm      = bin2bcd(set_min);
    assign w_ss      = bin2bcd(set_sec);
    assign w_last    = (r_h1 == 4'd2) && (r_h0 == 4'd3) && (r_m1 == 4'd5) &&
                       (r_m0 == 4'd9) && (r_s1 == 4'd5) && (r_s0 == 4'd9);

    always_comb begin
        w_inc_s0 = r_s0; w_inc_s1 = r_s1; w_inc_m0 = r_m0;
        w_inc_m1 = r_m1; w_inc_h0 = r_h0; w_inc_h1 = r_h1;
        if (r_s0 != 4'd9) w_inc_s0 = r_s0 + 4'd1;
        else begin
            w_inc_s0 = 4'd0;
            if (r_s1 != 4'd5) w_inc_s1 = r_s1 + 4'd1;
            else begin
                w_inc_s1 = 4'd0;
                if (r_m0 != 4'd9) w_inc_m0 = r_m0 + 4'd1;
                else begin
                    w_inc_m0 = 4'd0;
                    if (r_m1 != 4'd5) w_inc_m1 = r_m1 + 4'd1;
                    else begin
                        w_inc_m1 = 4'd0;
                        if (r_h1 == 4'd2 && r_h0 == 4'd3) begin
                            w_inc_h1 = 4'd0;
                            w_inc_h0 = 4'd0;
                        end else if (r_h0 == 4'd9) begin
                            w_inc_h0 = 4'd0;
                            w_inc_h1 = r_h1 + 4'd1;
                        end else begin
                            w_inc_h0 = r_h0 + 4'd1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        w_nx_s0 = r_s0; w_nx_s1 = r_s1; w_nx_m0 = r_m0;
        w_nx_m1 = r_m1; w_nx_h0 = r_h0; w_nx_h1 = r_h1;
        if (w_set_go) begin
            {w_nx_h1, w_nx_h0} = w_sh;
            {w_nx_m1, w_nx_m0} = w_sm;
            {w_nx_s1, w_nx_s0} = w_ss;
        end else if (w_step_go) begin
            w_nx_s0 = w_inc_s0; w_nx_s1 = w_inc_s1; w_nx_m0 = w_inc_m0;
            w_nx_m1 = w_inc_m1; w_nx_h0 = w_inc_h0; w_nx_h1 = w_inc_h1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p        <= '0;
            r_s0       <= INIT_S0;
            r_s1       <= INIT_S1;
            r_m0       <= INIT_M0;
            r_m1       <= INIT_M1;
            r_h0       <= INIT_H0;
            r_h1       <= INIT_H1;
            r_set_ack  <= 1'b0;
            r_set_err  <= 1'b0;
            r_day_wrap <= 1'b0;
        end else begin
            r_s0       <= w_nx_s0;
            r_s1       <= w_nx_s1;
            r_m0       <= w_nx_m0;
            r_m1       <= w_nx_m1;
            r_h0       <= w_nx_h0;
            r_h1       <= w_nx_h1;
            r_set_ack  <= w_set_go;
            r_set_err  <= set_req && !w_set_ok;
            r_day_wrap <= w_step_go && w_last;
            // A rejected request freezes the prescaler so the swallowed step is delayed, not lost.
            if (set_req) begin
                if (w_set_ok) r_p <= '0;
            end else if (run) begin
                r_p <= w_step ? '0 : r_p + PW'(1);
            end
        end
    end

    assign w_hour_bin = 5'(r_h1) * 5'd10 + 5'(r_h0);
    assign w_h12      = (w_hour_bin == 5'd0)  ? 5'd12 :
                        (w_hour_bin > 5'd12)  ? w_hour_bin - 5'd12 : w_hour_bin;

    assign sec0     = r_s0;
    assign sec1     = r_s1;
    assign min0     = r_m0;
    assign min1     = r_m1;
    assign hour1    = mode_24h ? r_h1 : ((w_h12 >= 5'd10) ? 4'd1 : 4'd0);
    assign hour0    = mode_24h ? r_h0 : 4'((w_h12 >= 5'd10) ? w_h12 - 5'd10 : w_h12);
    assign pm       = (w_hour_bin >= 5'd12);
    assign set_ack  = r_set_ack;
    assign set_err  = r_set_err;
    assign day_wrap = r_day_wrap;

`ifdef TOD_ALARM_EN
    logic [3:0] r_al_h1, r_al_h0, r_al_m1, r_al_m0;
    logic       r_armed, r_alarm_hit;
    logic       w_al_ok, w_al_match;
    logic [7:0] w_al_h, w_al_m;

    assign w_al_ok    = (alarm_hour <= 5'd23) && (alarm_min <= 6'd59);
    assign w_al_h     = bin2bcd({1'b0, alarm_hour});
    assign w_al_m     = bin2bcd(alarm_min);
    assign w_al_match = (w_nx_h1 == r_al_h1) && (w_nx_h0 == r_al_h0) &&
                        (w_nx_m1 == r_al_m1) && (w_nx_m0 == r_al_m0) &&
                        (w_nx_s1 == 4'd0) && (w_nx_s0 == 4'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_al_h1     <= 4'd0;
            r_al_h0     <= 4'd0;
            r_al_m1     <= 4'd0;
            r_al_m0     <= 4'd0;
            r_armed     <= 1'b0;
            r_alarm_hit <= 1'b0;
        end else begin
            r_armed     <= alarm_arm;
            r_alarm_hit <= r_armed && w_upd && w_al_match;
            if (alarm_we && w_al_ok) begin
                {r_al_h1, r_al_h0} <= w_al_h;
                {r_al_m1, r_al_m0} <= w_al_m;
            end
        end
    end

    assign alarm_hit = r_alarm_hit;
`else
    logic w_unused_alarm;
    assign w_unused_alarm = ^{alarm_we, alarm_hour, alarm_min, alarm_arm, w_upd};
    assign alarm_hit      = 1'b0;
`endif

endmodule

// File: tb/tb_tod_counter.sv
// Directed bench for tod_counter: one instance at DIV_CNT=1/INIT 11:59:58, one at DIV_CNT=4/INIT 0.
// Alarm expectations follow TOD_ALARM_EN.
module tb_tod_counter;

`ifdef TOD_ALARM_EN
    localparam logic ALARM_ON = 1'b1;
`else
    localparam logic ALARM_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n, run, run4, mode_24h, set_req, set_req4;
    logic [4:0] set_hour;
    logic [5:0] set_min, set_sec;
    logic       alarm_we, alarm_arm;
    logic [4:0] alarm_hour;
    logic [5:0] alarm_min;

    logic       d_ack, d_err, d_pm, d_wrap, d_hit;
    logic [3:0] d_s0, d_s1, d_m0, d_m1, d_h0, d_h1;
    logic       q_ack, q_err, q_pm, q_wrap, q_hit;
    logic [3:0] q_s0, q_s1, q_m0, q_m1, q_h0, q_h1;
    logic [23:0] tod_d, tod_q;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    assign tod_d = {d_h1, d_h0, d_m1, d_m0, d_s1, d_s0};
    assign tod_q = {q_h1, q_h0, q_m1, q_m0, q_s1, q_s0};

    tod_counter #(.DIV_CNT(1), .INIT_HOUR(11), .INIT_MIN(59), .INIT_SEC(58)) u_dut (
        .clk(clk), .rst_n(rst_n), .run(run), .mode_24h(mode_24h),
        .set_req(set_req), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_ack(d_ack), .set_err(d_err),
        .sec0(d_s0), .sec1(d_s1), .min0(d_m0), .min1(d_m1), .hour0(d_h0), .hour1(d_h1),
        .pm(d_pm), .day_wrap(d_wrap),
        .alarm_we(alarm_we), .alarm_hour(alarm_hour), .alarm_min(alarm_min),
        .alarm_arm(alarm_arm), .alarm_hit(d_hit)
    );

    tod_counter #(.DIV_CNT(4)) u_div4 (
        .clk(clk), .rst_n(rst_n), .run(run4), .mode_24h(1'b1),
        .set_req(set_req4), .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
        .set_ack(q_ack), .set_err(q_err),
        .sec0(q_s0), .sec1(q_s1), .min0(q_m0), .min1(q_m1), .hour0(q_h0), .hour1(q_h1),
        .pm(q_pm), .day_wrap(q_wrap),
        .alarm_we(1'b0), .alarm_hour(5'd0), .alarm_min(6'd0),
        .alarm_arm(1'b0), .alarm_hit(q_hit)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_time(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        set_hour = h;
        set_min  = m;
        set_sec  = s;
    endtask

    initial begin
        rst_n = 1'b1; run = 1'b0; run4 = 1'b0; mode_24h = 1'b1;
        set_req = 1'b0; set_req4 = 1'b0; set_time(5'd0, 6'd0, 6'd0);
        alarm_we = 1'b0; alarm_arm = 1'b0; alarm_hour = 5'd0; alarm_min = 6'd0;
        #1 rst_n = 1'b0;
        #1;
        chk("rst_tod",   tod_d,  24'h115958);
        chk("rst_ack",   d_ack,  0);
        chk("rst_err",   d_err,  0);
        chk("rst_wrap",  d_wrap, 0);
        chk("rst_pm",    d_pm,   0);
        chk("rst_hit",   d_hit,  0);
        chk("rst_tod4",  tod_q,  24'h000000);

        // Free run across noon
        tick();
        rst_n = 1'b1; run = 1'b1;
        chk("run_t0", tod_d, 24'h115958);
        tick();
        chk("run_t1",    tod_d, 24'h115959);
        chk("run_t1_pm", d_pm,  0);
        tick();
        chk("run_t2",    tod_d, 24'h120000);
        chk("run_t2_pm", d_pm,  1);

        // Midnight in 12h mode
        mode_24h = 1'b0; set_req = 1'b1; set_time(5'd23, 6'd59, 6'd58);
        tick();
        set_req = 1'b0;
        chk("mid_set",   tod_d, 24'h115958);
        chk("mid_pm0",   d_pm,  1);
        chk("mid_ack",   d_ack, 1);
        tick();
        chk("mid_59",    tod_d, 24'h115959);
        chk("mid_ack1",  d_ack, 0);
        chk("mid_wrap0", d_wrap, 0);
        tick();
        chk("mid_00",    tod_d, 24'h120000);
        chk("mid_pm1",   d_pm,  0);
        chk("mid_wrap",  d_wrap, 1);
        tick();
        chk("mid_01",    tod_d, 24'h120001);
        chk("mid_wrap1", d_wrap, 0);

        // Rejected loads leave time untouched
        run = 1'b0; set_req = 1'b1; set_time(5'd10, 6'd60, 6'd0);
        tick();
        chk("bad_min_err", d_err, 1);
        chk("bad_min_ack", d_ack, 0);
        chk("bad_min_tod", tod_d, 24'h120001);
        set_time(5'd24, 6'd0, 6'd0);
        tick();
        chk("bad_hr_err", d_err, 1);
        set_time(5'd1, 6'd2, 6'd60);
        tick();
        chk("bad_sec_err", d_err, 1);
        set_req = 1'b0;
        tick();
        chk("bad_err_clr", d_err, 0);
        mode_24h = 1'b1;
        #1 chk("bad_tod24", tod_d, 24'h000001);

        // Held request reloads every cycle
        set_req = 1'b1; set_time(5'd5, 6'd6, 6'd7);
        tick();
        chk("hold_t0",   tod_d, 24'h050607);
        chk("hold_ack0", d_ack, 1);
        set_time(5'd13, 6'd14, 6'd15);
        tick();
        chk("hold_t1",   tod_d, 24'h131415);
        chk("hold_ack1", d_ack, 1);
        mode_24h = 1'b0;
        #1 chk("hold_12h", tod_d, 24'h011415);
        chk("hold_pm", d_pm, 1);
        set_req = 1'b0; mode_24h = 1'b1;
        tick();
        chk("hold_ack2", d_ack, 0);

        // Alarm 00:01 armed, then disarmed
        alarm_we = 1'b1; alarm_hour = 5'd0; alarm_min = 6'd1; alarm_arm = 1'b1;
        tick();
        alarm_we = 1'b0;
        set_req = 1'b1; run = 1'b1; set_time(5'd0, 6'd0, 6'd59);
        tick();
        set_req = 1'b0;
        chk("al_t59",  tod_d, 24'h000059);
        chk("al_hit0", d_hit, 0);
        tick();
        chk("al_t100", tod_d, 24'h000100);
        chk("al_hit",  d_hit, ALARM_ON);
        tick();
        chk("al_hit1", d_hit, 0);
        alarm_arm = 1'b0; set_req = 1'b1;
        tick();
        set_req = 1'b0;
        tick();
        chk("dis_t100", tod_d, 24'h000100);
        chk("dis_hit",  d_hit, 0);
        run = 1'b0;

        // DIV_CNT=4 spacing, pause stretch, coincident set
        run4 = 1'b1;
        tick(3);
        chk("d4_s0", tod_q, 24'h000000);
        tick();
        chk("d4_s1", tod_q, 24'h000001);
        tick();
        run4 = 1'b0;
        tick(3);
        run4 = 1'b1;
        tick(2);
        chk("d4_pause", tod_q, 24'h000001);
        tick();
        chk("d4_s2", tod_q, 24'h000002);
        tick(3);
        chk("d4_pre", tod_q, 24'h000002);
        set_req4 = 1'b1; set_time(5'd5, 6'd6, 6'd7);
        tick();
        set_req4 = 1'b0;
        chk("d4_set",  tod_q, 24'h050607);
        chk("d4_ack",  q_ack, 1);
        tick(3);
        chk("d4_hold", tod_q, 24'h050607);
        chk("d4_ack1", q_ack, 0);
        tick();
        chk("d4_step", tod_q, 24'h050608);
        chk("d4_misc", {q_err, q_pm, q_wrap, q_hit}, 4'b0000);
        run4 = 1'b0;

        // Reset during a set request
        set_req = 1'b1; set_time(5'd7, 6'd8, 6'd9);
        tick();
        chk("rs_ack", d_ack, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rs_tod",  tod_d, 24'h115958);
        chk("rs_ack0", d_ack, 0);
        set_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("rs_ack1", d_ack, 0);
        chk("rs_tod1", tod_d, 24'h115958);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
